// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with per-frame debounce.
// Drives one column low at a time, samples the active-low rows at the end of
// each column dwell, classifies every full frame as NONE / SINGLE / MULTI, and
// runs a press/release debounce FSM on those frames.
// Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat of keyValid
// while a key stays held (REPEAT_DELAY frames first, then every REPEAT_PERIOD).
// keyRow is sampled directly; it is expected to be synchronous to clock (the
// column drive itself is the stimulus, so the row lines settle within a dwell).

module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_DELAY   = 500,
    parameter int unsigned REPEAT_PERIOD  = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] keyRow,
    output logic [3:0] keyCol,
    output logic [3:0] keypadButton,
    output logic       keyValid,
    output logic       keyHeld
);

    localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_DONE    = DB_W'(DEBOUNCE_SCANS);

    // Frame classification accumulated across the four column samples
    localparam logic [1:0] HITS_NONE  = 2'd0;
    localparam logic [1:0] HITS_ONE   = 2'd1;
    localparam logic [1:0] HITS_MULTI = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_DB,
        S_HELD,
        S_REL_DB
    } state_t;

    // Reject illegal configurations at elaboration
    generate
        if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
            $error("keypad_scanner: illegal parameter value");
        end
    endgenerate

    // Scan state
    logic [DIV_W-1:0] r_dwell;
    logic [1:0]       r_col;
    logic [3:0]       r_key_col;
    logic [1:0]       r_hits;
    logic [3:0]       r_code;

    // Debounce FSM state and registered outputs
    state_t           r_state;
    logic [3:0]       r_cand;
    logic [DB_W-1:0]  r_db_cnt;
    logic [3:0]       r_button;
    logic             r_valid;
    logic             r_held;

    // Combinational frame decode
    logic [3:0]       w_row_low;
    logic [2:0]       w_col_hits;
    logic [3:0]       w_col_code;
    logic [1:0]       w_hits;
    logic [3:0]       w_code;
    logic [1:0]       w_col_next;
    logic             w_sample;
    logic             w_frame_end;
    logic [DB_W-1:0]  w_db_inc;
    logic             w_match_held;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_phase;
    logic [REP_W-1:0] w_rep_inc;
    logic [REP_W-1:0] w_rep_target;
`endif

    // Key code at a given column/row position of the matrix
    function automatic logic [3:0] f_code(input logic [1:0] col, input logic [1:0] row);
        logic [3:0] code;
        case ({col, row})
            4'h0: code = 4'h1;
            4'h1: code = 4'h4;
            4'h2: code = 4'h7;
            4'h3: code = 4'h0;
            4'h4: code = 4'h2;
            4'h5: code = 4'h5;
            4'h6: code = 4'h8;
            4'h7: code = 4'hF;
            4'h8: code = 4'h3;
            4'h9: code = 4'h6;
            4'hA: code = 4'h9;
            4'hB: code = 4'hE;
            4'hC: code = 4'hA;
            4'hD: code = 4'hB;
            4'hE: code = 4'hC;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Merge the current column's rows into the running frame classification
    always_comb begin
        w_row_low   = ~keyRow;
        w_col_hits  = 3'(w_row_low[0]) + 3'(w_row_low[1]) + 3'(w_row_low[2]) + 3'(w_row_low[3]);
        w_col_code  = 4'h0;
        for (int r = 3; r >= 0; r--) begin
            if (w_row_low[r]) begin
                w_col_code = f_code(r_col, 2'(r));
            end
        end

        if (r_hits == HITS_MULTI || w_col_hits > 3'd1) begin
            w_hits = HITS_MULTI;
        end else if (r_hits == HITS_ONE && w_col_hits == 3'd1) begin
            w_hits = HITS_MULTI;
        end else if (r_hits == HITS_ONE || w_col_hits == 3'd1) begin
            w_hits = HITS_ONE;
        end else begin
            w_hits = HITS_NONE;
        end

        w_code       = (r_hits == HITS_ONE) ? r_code : w_col_code;
        w_col_next   = r_col + 2'd1;
        w_sample     = (r_dwell == DWELL_LAST);
        w_frame_end  = w_sample && (r_col == 2'd3);
        w_db_inc     = (r_db_cnt >= DB_DONE) ? DB_DONE : r_db_cnt + DB_W'(1);
        w_match_held = (w_hits == HITS_ONE) && (w_code == r_button);
    end

`ifdef KEYPAD_REPEAT_EN
    // Repeat counter helpers: first interval is the delay, then the period
    always_comb begin
        w_rep_inc    = r_rep_cnt + REP_W'(1);
        w_rep_target = r_rep_phase ? REP_W'(REPEAT_PERIOD) : REP_W'(REPEAT_DELAY);
    end
`endif

    // Column dwell timing, column drive and per-frame row accumulation
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dwell   <= '0;
            r_col     <= 2'd0;
            r_key_col <= 4'b1110;
            r_hits    <= HITS_NONE;
            r_code    <= 4'h0;
        end else if (w_sample) begin
            r_dwell   <= '0;
            r_col     <= w_col_next;
            r_key_col <= ~(4'b0001 << w_col_next);
            if (w_frame_end) begin
                r_hits <= HITS_NONE;
                r_code <= 4'h0;
            end else begin
                r_hits <= w_hits;
                r_code <= w_code;
            end
        end else begin
            r_dwell <= r_dwell + DIV_W'(1);
        end
    end

    // Debounce FSM evaluated once per frame end; MULTI frames leave everything untouched
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cand      <= 4'h0;
            r_db_cnt    <= '0;
            r_button    <= 4'h0;
            r_valid     <= 1'b0;
            r_held      <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            if (w_frame_end && w_hits != HITS_MULTI) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_hits == HITS_ONE) begin
                            r_cand   <= w_code;
                            r_db_cnt <= DB_W'(1);
                            r_state  <= S_PRESS_DB;
                        end
                    end
                    S_PRESS_DB: begin
                        if (w_hits == HITS_NONE) begin
                            r_db_cnt <= '0;
                            r_state  <= S_IDLE;
                        end else if (w_code != r_cand) begin
                            r_cand   <= w_code;
                            r_db_cnt <= DB_W'(1);
                        end else if (w_db_inc == DB_DONE) begin
                            r_button <= r_cand;
                            r_valid  <= 1'b1;
                            r_held   <= 1'b1;
                            r_db_cnt <= '0;
                            r_state  <= S_HELD;
                        end else begin
                            r_db_cnt <= w_db_inc;
                        end
                    end
                    S_HELD: begin
                        if (w_match_held) begin
`ifdef KEYPAD_REPEAT_EN
                            if (w_rep_inc == w_rep_target) begin
                                r_valid     <= 1'b1;
                                r_rep_cnt   <= '0;
                                r_rep_phase <= 1'b1;
                            end else begin
                                r_rep_cnt   <= w_rep_inc;
                            end
`endif
                        end else begin
                            r_db_cnt    <= DB_W'(1);
                            r_state     <= S_REL_DB;
`ifdef KEYPAD_REPEAT_EN
                            r_rep_cnt   <= '0;
                            r_rep_phase <= 1'b0;
`endif
                        end
                    end
                    S_REL_DB: begin
                        if (w_match_held) begin
                            r_db_cnt <= '0;
                            r_state  <= S_HELD;
                        end else if (w_db_inc == DB_DONE) begin
                            r_held   <= 1'b0;
                            r_db_cnt <= '0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_db_cnt <= w_db_inc;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign keyCol       = r_key_col;
    assign keypadButton = r_button;
    assign keyValid     = r_valid;
    assign keyHeld      = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a frame-level
// reference model (keys pressed are a 16-bit set indexed by key code).
// Honours KEYPAD_REPEAT_EN when defined.

module tb_keypad_scanner;

    localparam int unsigned SD    = 4;
    localparam int unsigned DB    = 3;
    localparam int unsigned RD    = 4;
    localparam int unsigned RP    = 2;
    localparam int unsigned FRAME = 4 * SD;
`ifdef KEYPAD_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [3:0]  keyRow;
    logic [3:0]  keyCol;
    logic [3:0]  keypadButton;
    logic        keyValid;
    logic        keyHeld;

    logic [15:0] mask;
    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned n_pulses;

    keypad_scanner #(
        .SCAN_DIV      (SD),
        .DEBOUNCE_SCANS(DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .keyRow      (keyRow),
        .keyCol      (keyCol),
        .keypadButton(keypadButton),
        .keyValid    (keyValid),
        .keyHeld     (keyHeld)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Key code at matrix position (col, row)
    function automatic logic [3:0] key_at(input int c, input int r);
        logic [63:0] keys;
        keys = 64'hDCBA_E963_F852_0741;
        return keys[(c * 4 + r) * 4 +: 4];
    endfunction

    // Physical keypad: a pressed key shorts its row to the driven column
    always_comb begin
        keyRow = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!keyCol[c] && mask[key_at(c, r)]) begin
                    keyRow[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Hold a key set for n whole frames; returns 1 time unit into the next frame
    task automatic run_frames(input logic [15:0] m, input int n);
        mask = m;
        repeat (n * FRAME) @(posedge clock);
        #1;
    endtask

    // Reference model and per-cycle comparison
    initial begin : compare
        int unsigned p;
        int unsigned ones;
        int unsigned m_streak;
        int unsigned m_rel;
        int unsigned m_rep;
        logic [15:0] fmask;
        logic [3:0]  code;
        logic [3:0]  m_cand;
        logic [3:0]  m_key;
        logic [3:0]  exp_col;
        logic        m_held;
        logic        exp_valid;
        p = 0; fmask = '0; m_streak = 0; m_rel = 0; m_rep = 0;
        m_cand = '0; m_key = '0; m_held = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                p = 0; fmask = '0; m_streak = 0; m_rel = 0; m_rep = 0;
                m_cand = '0; m_key = '0; m_held = 1'b0;
            end else begin
                exp_valid = 1'b0;
                if (p > 0 && p % FRAME == 0) begin
                    ones = $countones(fmask);
                    code = '0;
                    for (int k = 0; k < 16; k++) begin
                        if (fmask[k]) code = 4'(k);
                    end
                    if (ones <= 1) begin
                        if (!m_held) begin
                            if (ones == 0) m_streak = 0;
                            else if (m_streak > 0 && code == m_cand) m_streak++;
                            else begin m_cand = code; m_streak = 1; end
                            if (m_streak == DB) begin
                                m_key = m_cand; m_held = 1'b1; exp_valid = 1'b1;
                                m_streak = 0; m_rel = 0; m_rep = 0;
                            end
                        end else if (ones == 1 && code == m_key) begin
                            if (m_rel > 0) begin
                                m_rel = 0; m_rep = 0;
                            end else begin
                                m_rep++;
                                if (REP_ON && (m_rep == RD || (m_rep > RD && (m_rep - RD) % RP == 0)))
                                    exp_valid = 1'b1;
                            end
                        end else begin
                            m_rel++;
                            if (m_rel == DB) begin
                                m_held = 1'b0; m_rel = 0; m_streak = 0;
                            end
                        end
                    end
                end
                exp_col = ~(4'b0001 << 2'((p / SD) % 4));
                check("keyCol", 32'(keyCol), 32'(exp_col));
                check("keyValid", 32'(keyValid), 32'(exp_valid));
                check("keyHeld", 32'(keyHeld), 32'(m_held));
                check("keypadButton", 32'(keypadButton), 32'(m_key));
                if (keyValid) n_pulses++;
                if (p % FRAME == FRAME - 1) fmask = mask;
                p++;
            end
        end
    end

    // Directed stimulus with hand-computed expectations
    initial begin : stim
        logic [3:0]  cols [4];
        int unsigned n0;
        cols = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        n_checks = 0; n_errors = 0; n_pulses = 0;
        reset = 1'b1;
        mask  = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_keyCol", 32'(keyCol), 32'h0000_000E);
        check("rst_keyValid", 32'(keyValid), 32'h0);
        check("rst_keyHeld", 32'(keyHeld), 32'h0);
        check("rst_button", 32'(keypadButton), 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Idle column walk
        for (int i = 0; i < 4; i++) begin
            check("walk_keyCol", 32'(keyCol), 32'(cols[i]));
            repeat (SD) @(posedge clock);
            #1;
        end

        // '8' steady: one pulse after the 3rd frame, then held for 20 frames
        run_frames(16'h0100, 3);
        check("k8_valid", 32'(keyValid), 32'h1);
        check("k8_button", 32'(keypadButton), 32'h8);
        check("k8_held", 32'(keyHeld), 32'h1);
        n0 = n_pulses;
        run_frames(16'h0100, 20);
        check("k8_pulses", n_pulses - n0, REP_ON ? 32'd9 : 32'd1);
        run_frames(16'h0000, 3);
        check("k8_released", 32'(keyHeld), 32'h0);

        // '3' bouncing, then stable
        run_frames(16'h0008, 1);
        check("k3_b1", 32'(keyValid), 32'h0);
        run_frames(16'h0000, 1);
        run_frames(16'h0008, 1);
        check("k3_b2", 32'(keyHeld), 32'h0);
        run_frames(16'h0000, 1);
        run_frames(16'h0008, 2);
        check("k3_early", 32'(keyValid), 32'h0);
        run_frames(16'h0008, 1);
        check("k3_valid", 32'(keyValid), 32'h1);
        check("k3_button", 32'(keypadButton), 32'h3);
        run_frames(16'h0000, 3);

        // '1'+'2' together from idle, then MULTI inside a press debounce
        n0 = n_pulses;
        run_frames(16'h0006, 4);
        check("multi_held", 32'(keyHeld), 32'h0);
        check("multi_pulses", n_pulses - n0, 32'd0);
        run_frames(16'h0000, 1);
        run_frames(16'h0002, 1);
        run_frames(16'h0006, 1);
        run_frames(16'h0002, 2);
        check("k1_valid", 32'(keyValid), 32'h1);
        check("k1_button", 32'(keypadButton), 32'h1);
        run_frames(16'h0000, 3);

        // '5' held then released; then reset in the middle of a release debounce
        run_frames(16'h0020, 3);
        check("k5_button", 32'(keypadButton), 32'h5);
        run_frames(16'h0000, 2);
        check("k5_rel2_held", 32'(keyHeld), 32'h1);
        run_frames(16'h0000, 1);
        check("k5_rel3_held", 32'(keyHeld), 32'h0);
        check("k5_rel3_button", 32'(keypadButton), 32'h5);
        run_frames(16'h0020, 3);
        run_frames(16'h0000, 1);
        repeat (6) @(posedge clock);
        #3;
        check("pre_rst_held", 32'(keyHeld), 32'h1);
        reset = 1'b1;
        #1;
        check("mid_rst_keyCol", 32'(keyCol), 32'h0000_000E);
        check("mid_rst_button", 32'(keypadButton), 32'h0);
        check("mid_rst_valid", 32'(keyValid), 32'h0);
        check("mid_rst_held", 32'(keyHeld), 32'h0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("post_rst_dwell", 32'(keyCol), 32'h0000_000E);
        @(posedge clock);
        #1;
        check("post_rst_col1", 32'(keyCol), 32'h0000_000D);
        repeat (FRAME - SD) @(posedge clock);
        #1;

`ifdef KEYPAD_REPEAT_EN
        // 'A' held: repeats at +4, +6, +8, +10 frames after acceptance
        run_frames(16'h0400, 3);
        check("kA_valid", 32'(keyValid), 32'h1);
        n0 = n_pulses;
        run_frames(16'h0400, 11);
        check("kA_pulses", n_pulses - n0, 32'd5);
        check("kA_button", 32'(keypadButton), 32'hA);
        run_frames(16'h0000, 3);
`endif

        // Switching keys must pass through a full release first
        run_frames(16'h0040, 3);
        check("k6_button", 32'(keypadButton), 32'h6);
        run_frames(16'h0200, 3);
        check("k9_released6", 32'(keyHeld), 32'h0);
        check("k9_keep6", 32'(keypadButton), 32'h6);
        run_frames(16'h0200, 3);
        check("k9_valid", 32'(keyValid), 32'h1);
        check("k9_button", 32'(keypadButton), 32'h9);
        run_frames(16'h0000, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 100000, meaning clock cycles each column is driven (minimum 2).
REQ-002 The block SHALL have parameter DEBOUNCE_SCANS, default 4, meaning consecutive matching full scans (frames) needed to accept a press or release (minimum 2).
REQ-003 The block SHALL have parameter REPEAT_DELAY, default 500, meaning frames held before the first auto-repeat (used only with KEYPAD_REPEAT_EN).
REQ-004 The block SHALL have parameter REPEAT_PERIOD, default 100, meaning frames between auto-repeats (used only with KEYPAD_REPEAT_EN).
REQ-005 clock  input  1  system clock; all state on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 keyRow  input  4  keypad row sense, active low, externally pulled up; bit r = row r.
REQ-008 keyCol  output  4  keypad column drive; exactly one bit low (driven column), others high.
REQ-009 keypadButton  output  4  hex code of the last accepted key; held until the next accepted press.
REQ-010 keyValid  output  1  one-cycle pulse when keypadButton is updated (or auto-repeated).
REQ-011 keyHeld  output  1  high while the accepted key is considered pressed.

Function
REQ-012 Column index SHALL advance 0,1,2,3,0,... every SCAN_DIV cycles; keyCol = ~(1<<index).
REQ-013 keyRow SHALL be sampled on the last cycle of each column dwell; a frame ends at the column-3 sample.
REQ-014 Key code map: col0 rows0..3 = 1,4,7,0; col1 = 2,5,8,F; col2 = 3,6,9,E; col3 = A,B,C,D.
REQ-015 Frame result SHALL be NONE (no low row bit in any column), SINGLE(code) (exactly one), or MULTI (two or more).
REQ-016 A MULTI frame SHALL be ignored: no state, counter or output change.
REQ-017 FSM states IDLE, PRESS_DB, HELD, REL_DB, evaluated once per frame end.
REQ-018 IDLE: SINGLE(K) -> candidate=K, count=1, PRESS_DB; NONE -> stay.
REQ-019 PRESS_DB: SINGLE(K) equal to candidate -> count+1; a different SINGLE -> candidate=new, count=1; NONE -> IDLE.
REQ-020 PRESS_DB: when count reaches DEBOUNCE_SCANS -> keypadButton=candidate, keyValid=1 for the next cycle only, keyHeld=1, HELD.
REQ-021 HELD: SINGLE equal to the held key -> stay; NONE or a different SINGLE -> count=1, REL_DB.
REQ-022 REL_DB: frame not equal to the held key -> count+1; reaching DEBOUNCE_SCANS -> keyHeld=0, IDLE; SINGLE equal to the held key -> HELD.
REQ-023 A new key SHALL only be accepted after returning to IDLE (no direct key-to-key transition).
REQ-024 Press latency SHALL be 1 cycle after the column-3 sample of the DEBOUNCE_SCANS-th matching frame.
REQ-025 Debounce count SHALL saturate at DEBOUNCE_SCANS; the dwell counter SHALL wrap from SCAN_DIV-1 to 0.

Reset
REQ-026 On reset asserted (at any time, including mid-dwell or mid-debounce), immediately: keyCol=4'b1110, keypadButton=0, keyValid=0, keyHeld=0, state IDLE, all counters 0.
REQ-027 After reset deasserts, scanning SHALL restart at column 0 with a full SCAN_DIV dwell.

Configuration
REQ-028 With macro KEYPAD_REPEAT_EN defined: in HELD, after REPEAT_DELAY frames keyValid SHALL pulse, then every REPEAT_PERIOD frames, with keypadButton unchanged; the repeat counter clears on leaving HELD.
REQ-029 Without KEYPAD_REPEAT_EN: exactly one keyValid pulse per accepted press; repeat logic absent.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3, frame = 16 cycles)
REQ-030 Reset, keyRow=4'hF -> keyCol=1110, then 1101, 1011, 0111 at 4-cycle steps; keyValid never asserted.
REQ-031 '8' (col1, row2) held steady -> one keyValid pulse 1 cycle after the 3rd frame end, keypadButton=4'h8, keyHeld=1; no further pulse over 20 frames (macro off).
REQ-032 '3' bouncing (pressed, released, pressed) then stable -> no pulse until 3 consecutive pressed frames; then keypadButton=4'h3.
REQ-033 '1' and '2' pressed together from IDLE -> MULTI frames, no keyValid, keyHeld stays 0.
REQ-034 Held '5' released -> keyHeld=0 after the 3rd NONE frame end, keypadButton stays 4'h5; reset pulse mid-REL_DB -> all outputs at reset values immediately.
REQ-035 Macro on, REPEAT_DELAY=4, REPEAT_PERIOD=2, 'A' held 10 frames after acceptance -> pulses at acceptance, +4, +6, +8, +10 frames; keypadButton=4'hA throughout.
